// File: rtl/pi_seq_cntrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pi_seq_pkg
//  Description : Shared types and constants for the PI-control sequencer and
//                the ALU operand muxes (state encoding, operand select codes,
//                sensor-to-A2D-channel table).
//  Revision    : 1.0  initial release
// ============================================================================
package pi_seq_pkg;

    // Sequencer states, 4-bit encoding
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SETTLE = 4'd1,
        S_CONV   = 4'd2,
        S_WAIT   = 4'd3,
        S_ACC    = 4'd4,
        S_INTG   = 4'd5,
        S_ICMP   = 4'd6,
        S_PCMP   = 4'd7,
        S_RHT0   = 4'd8,
        S_RHT1   = 4'd9,
        S_LFT0   = 4'd10,
        S_LFT1   = 4'd11,
        S_DONE   = 4'd12
    } state_t;

    // src1 operand select codes
    localparam logic [2:0] C_SRC1_ACCUM  = 3'd0;
    localparam logic [2:0] C_SRC1_ITERM  = 3'd1;
    localparam logic [2:0] C_SRC1_ERR    = 3'd2;
    localparam logic [2:0] C_SRC1_ERRDIV = 3'd3;
    localparam logic [2:0] C_SRC1_FWD    = 3'd4;

    // src0 operand select codes
    localparam logic [2:0] C_SRC0_A2D    = 3'd0;
    localparam logic [2:0] C_SRC0_INTGRL = 3'd1;
    localparam logic [2:0] C_SRC0_ICOMP  = 3'd2;
    localparam logic [2:0] C_SRC0_PCOMP  = 3'd3;
    localparam logic [2:0] C_SRC0_PTERM  = 3'd4;

    // Six IR sensors are converted per control cycle; index 5 is the last
    localparam logic [2:0] C_LAST_IDX = 3'd5;

    // A2D channel for each conversion index (index 0 in the low slot).
    // Even indices are right-side sensors, odd indices left-side sensors.
    localparam logic [5:0][2:0] C_CHAN = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1};

    // Channel lookup guarded against indices past the table
    function automatic logic [2:0] chan_of(input logic [2:0] idx);
        logic [2:0] ch;
        ch = 3'd0;
        case (idx)
            3'd0:    ch = C_CHAN[0];
            3'd1:    ch = C_CHAN[1];
            3'd2:    ch = C_CHAN[2];
            3'd3:    ch = C_CHAN[3];
            3'd4:    ch = C_CHAN[4];
            3'd5:    ch = C_CHAN[5];
            default: ch = 3'd0;
        endcase
        return ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pi_seq_cntrl.sv
`default_nettype none
// ============================================================================
//  Module      : pi_seq_cntrl
//  Description : Control-cycle sequencer for the shared PI ALU. Walks six
//                IR-sensor conversions through the A2D while accumulating a
//                weighted error, then schedules integral, I-term, P-term and
//                the two motor-duty computations through the ALU. Owns all
//                ALU control lines and the result registers feeding the
//                ALU operand muxes.
//  Revision    : 1.0  initial release
// ============================================================================
module pi_seq_cntrl
    import pi_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int INT_DEC    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        cnv_cmplt,
    input  logic [15:0] dst,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [2:0]  src1sel,
    output logic [2:0]  src0sel,
    output logic        mult2,
    output logic        mult4,
    output logic        sub,
    output logic        multiply,
    output logic        saturate,
    output logic [15:0] Accum,
    output logic [15:0] Pcomp,
    output logic [11:0] Error,
    output logic [11:0] Intgrl,
    output logic [11:0] Icomp,
    output logic [11:0] lft,
    output logic [11:0] rht,
    output logic        busy,
    output logic        done
);

    // Counter widths; a 1-bit counter is kept even when only one value is used
    localparam int C_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int C_DEC_W = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;
    localparam logic [C_SET_W-1:0] C_SET_LAST = C_SET_W'(SETTLE_CYC - 1);
    localparam logic [C_DEC_W-1:0] C_DEC_LAST = C_DEC_W'(INT_DEC - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [2:0]           r_idx;
    logic [C_SET_W-1:0]   r_settle_cnt;
    logic [C_DEC_W-1:0]   r_dec_cnt;
    logic                 w_settle_done;
    logic                 w_last_sensor;
    logic                 w_intg_update;

    assign w_settle_done = (r_settle_cnt == C_SET_LAST);
    assign w_last_sensor = (r_idx == C_LAST_IDX);
    assign w_intg_update = (r_dec_cnt == C_DEC_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and Moore decode of ALU controls / handshakes
    always_comb begin
        w_next_state = r_state;
        strt_cnv     = 1'b0;
        done         = 1'b0;
        src1sel      = 3'd0;
        src0sel      = 3'd0;
        mult2        = 1'b0;
        mult4        = 1'b0;
        sub          = 1'b0;
        multiply     = 1'b0;
        saturate     = 1'b0;
        busy         = (r_state != S_IDLE) && (r_state != S_DONE);

        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_settle_done) begin
                    w_next_state = S_CONV;
                end
            end
            S_CONV: begin
                strt_cnv     = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (cnv_cmplt) begin
                    w_next_state = S_ACC;
                end
            end
            S_ACC: begin
                // Outer sensors carry more weight; left sensors subtract
                src1sel  = C_SRC1_ACCUM;
                src0sel  = C_SRC0_A2D;
                mult2    = (r_idx == 3'd2) || (r_idx == 3'd3);
                mult4    = (r_idx == 3'd4) || (r_idx == 3'd5);
                sub      = r_idx[0];
                saturate = w_last_sensor;
                w_next_state = w_last_sensor ? S_INTG : S_SETTLE;
            end
            S_INTG: begin
                src1sel      = C_SRC1_ERRDIV;
                src0sel      = C_SRC0_INTGRL;
                saturate     = 1'b1;
                w_next_state = S_ICMP;
            end
            S_ICMP: begin
                src1sel      = C_SRC1_ITERM;
                src0sel      = C_SRC0_INTGRL;
                multiply     = 1'b1;
                w_next_state = S_PCMP;
            end
            S_PCMP: begin
                src1sel      = C_SRC1_ERR;
                src0sel      = C_SRC0_PTERM;
                multiply     = 1'b1;
                w_next_state = S_RHT0;
            end
            S_RHT0: begin
                src1sel      = C_SRC1_FWD;
                src0sel      = C_SRC0_PCOMP;
                sub          = 1'b1;
                w_next_state = S_RHT1;
            end
            S_RHT1: begin
                src1sel      = C_SRC1_ACCUM;
                src0sel      = C_SRC0_ICOMP;
                sub          = 1'b1;
                saturate     = 1'b1;
                w_next_state = S_LFT0;
            end
            S_LFT0: begin
                src1sel      = C_SRC1_FWD;
                src0sel      = C_SRC0_PCOMP;
                w_next_state = S_LFT1;
            end
            S_LFT1: begin
                src1sel      = C_SRC1_ACCUM;
                src0sel      = C_SRC0_ICOMP;
                saturate     = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Settling delay after each channel change; clears itself on expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
        end else if (r_state == S_SETTLE) begin
            if (w_settle_done) begin
                r_settle_cnt <= '0;
            end else begin
                r_settle_cnt <= r_settle_cnt + C_SET_W'(1);
            end
        end
    end

    // Sensor index and A2D channel select
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= 3'd0;
            chnnl <= 3'd0;
        end else if ((r_state == S_IDLE) && go) begin
            r_idx <= 3'd0;
            chnnl <= chan_of(3'd0);
        end else if ((r_state == S_ACC) && !w_last_sensor) begin
            r_idx <= r_idx + 3'd1;
            chnnl <= chan_of(r_idx + 3'd1);
        end
    end

    // Integral decimation: counts every INTG pass, wraps at INT_DEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_cnt <= '0;
        end else if (r_state == S_INTG) begin
            if (w_intg_update) begin
                r_dec_cnt <= '0;
            end else begin
                r_dec_cnt <= r_dec_cnt + C_DEC_W'(1);
            end
        end
    end

    // Result registers, each captured at the closing edge of its ALU step
    always_ff @(posedge clk) begin
        if (rst) begin
            Accum  <= 16'h0000;
            Pcomp  <= 16'h0000;
            Error  <= 12'h000;
            Intgrl <= 12'h000;
            Icomp  <= 12'h000;
            lft    <= 12'h000;
            rht    <= 12'h000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        Accum <= 16'h0000;
                    end
                end
                S_ACC: begin
                    Accum <= dst;
                    if (w_last_sensor) begin
                        Error <= dst[11:0];
                    end
                end
                S_INTG: begin
                    if (w_intg_update) begin
                        Intgrl <= dst[11:0];
                    end
                end
                S_ICMP: Icomp <= dst[11:0];
                S_PCMP: Pcomp <= dst;
                S_RHT0: Accum <= dst;
                S_RHT1: rht   <= dst[11:0];
                S_LFT0: Accum <= dst;
                S_LFT1: lft   <= dst[11:0];
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pi_seq_cntrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pi_seq_cntrl
//  Description : Self-checking bench for pi_seq_cntrl. Two instances (INT_DEC
//                4 and 1) run in lockstep, each with its own behavioural ALU.
//                Expected results of every control cycle are queued at go and
//                compared when done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pi_seq_cntrl;

    localparam int          SETTLE  = 16;
    localparam int          INT_DEC_A = 4;
    localparam logic [15:0] ITERM   = 16'h0380;
    localparam logic [15:0] PTERM   = 16'h0280;
    localparam logic [15:0] FWD     = 16'h0300;

    typedef struct packed {
        logic [15:0] accum;
        logic [15:0] pcomp;
        logic [11:0] error;
        logic [11:0] intgrl;
        logic [11:0] icomp;
        logic [11:0] lft;
        logic [11:0] rht;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic        cnv_cmplt;
    logic [11:0] a2d_res;

    logic        strt_cnv_a, strt_cnv_b, busy_a, busy_b, done_a, done_b;
    logic [2:0]  chnnl_a, chnnl_b, src1sel_a, src1sel_b, src0sel_a, src0sel_b;
    logic        mult2_a, mult4_a, sub_a, multiply_a, saturate_a;
    logic        mult2_b, mult4_b, sub_b, multiply_b, saturate_b;
    logic [15:0] dst_a, dst_b, accum_a, accum_b, pcomp_a, pcomp_b;
    logic [11:0] error_a, error_b, intgrl_a, intgrl_b, icomp_a, icomp_b;
    logic [11:0] lft_a, lft_b, rht_a, rht_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          strt_high = 0;
    int          strt_idx  = 0;
    int          cnv_delay [6];
    logic [11:0] chan_val [8];
    logic [5:0][2:0] chan_log;
    sb_t         sb_q [$];
    sb_t         mon_e;
    logic [11:0] intg_a = 12'h000;
    logic [11:0] intg_b = 12'h000;
    int          pass_a = 0;

    always #5 clk = ~clk;

    // ---------------- helpers / behavioural ALU ----------------
    function automatic logic [15:0] sx(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

    function automatic logic [15:0] sat12(input logic [15:0] v);
        if ($signed(v) > 16'sd2047)       return 16'h07FF;
        else if ($signed(v) < -16'sd2048) return 16'hF800;
        else                              return v;
    endfunction

    function automatic logic [15:0] mulq(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        return p[23:8];
    endfunction

    function automatic logic [2:0] tb_chan(input logic [2:0] i);
        case (i)
            3'd0: return 3'd1;
            3'd1: return 3'd0;
            3'd2: return 3'd4;
            3'd3: return 3'd2;
            3'd4: return 3'd3;
            3'd5: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [15:0] alu_model(
        input logic [2:0] s1, input logic [2:0] s0,
        input logic m2, input logic m4, input logic sb, input logic mul, input logic sat,
        input logic [15:0] acc, input logic [15:0] pc,
        input logic [11:0] er, input logic [11:0] ig, input logic [11:0] ic,
        input logic [11:0] ad);
        logic [15:0] a, b, r;
        case (s1)
            3'd0: a = acc;
            3'd1: a = ITERM;
            3'd2: a = sx(er);
            3'd3: a = {{8{er[11]}}, er[11:4]};
            3'd4: a = FWD;
            default: a = 16'h0000;
        endcase
        case (s0)
            3'd0: b = {4'h0, ad};
            3'd1: b = sx(ig);
            3'd2: b = sx(ic);
            3'd3: b = pc;
            3'd4: b = PTERM;
            default: b = 16'h0000;
        endcase
        if (m4)      b = b << 2;
        else if (m2) b = b << 1;
        if (mul)     r = mulq(a, b);
        else if (sb) r = a - b;
        else         r = a + b;
        if (sat)     r = sat12(r);
        return r;
    endfunction

    // Reference result of one control cycle from the six sensor readings
    function automatic exp_t model(input logic [5:0][11:0] sv, input logic [11:0] ig_prev,
                                   input logic upd);
        exp_t        r;
        logic [15:0] acc, v, errdiv, tmp, racc;
        acc = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            v = {4'h0, sv[i]};
            if (i >= 4)      v = v << 2;
            else if (i >= 2) v = v << 1;
            acc = (i % 2 == 1) ? acc - v : acc + v;
        end
        acc     = sat12(acc);
        r.error = acc[11:0];
        errdiv  = {{8{r.error[11]}}, r.error[11:4]};
        tmp     = sat12(sx(ig_prev) + errdiv);
        r.intgrl = upd ? tmp[11:0] : ig_prev;
        tmp     = mulq(ITERM, sx(r.intgrl));
        r.icomp = tmp[11:0];
        r.pcomp = mulq(sx(r.error), PTERM);
        racc    = FWD - r.pcomp;
        tmp     = sat12(racc - sx(r.icomp));
        r.rht   = tmp[11:0];
        r.accum = FWD + r.pcomp;
        tmp     = sat12(r.accum + sx(r.icomp));
        r.lft   = tmp[11:0];
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- DUTs ----------------
    assign dst_a = alu_model(src1sel_a, src0sel_a, mult2_a, mult4_a, sub_a, multiply_a,
                             saturate_a, accum_a, pcomp_a, error_a, intgrl_a, icomp_a, a2d_res);
    assign dst_b = alu_model(src1sel_b, src0sel_b, mult2_b, mult4_b, sub_b, multiply_b,
                             saturate_b, accum_b, pcomp_b, error_b, intgrl_b, icomp_b, a2d_res);

    pi_seq_cntrl #(.SETTLE_CYC(SETTLE), .INT_DEC(INT_DEC_A)) dut_a (
        .clk(clk), .rst(rst), .go(go), .cnv_cmplt(cnv_cmplt), .dst(dst_a),
        .strt_cnv(strt_cnv_a), .chnnl(chnnl_a), .src1sel(src1sel_a), .src0sel(src0sel_a),
        .mult2(mult2_a), .mult4(mult4_a), .sub(sub_a), .multiply(multiply_a),
        .saturate(saturate_a), .Accum(accum_a), .Pcomp(pcomp_a), .Error(error_a),
        .Intgrl(intgrl_a), .Icomp(icomp_a), .lft(lft_a), .rht(rht_a),
        .busy(busy_a), .done(done_a));

    pi_seq_cntrl #(.SETTLE_CYC(SETTLE), .INT_DEC(1)) dut_b (
        .clk(clk), .rst(rst), .go(go), .cnv_cmplt(cnv_cmplt), .dst(dst_b),
        .strt_cnv(strt_cnv_b), .chnnl(chnnl_b), .src1sel(src1sel_b), .src0sel(src0sel_b),
        .mult2(mult2_b), .mult4(mult4_b), .sub(sub_b), .multiply(multiply_b),
        .saturate(saturate_b), .Accum(accum_b), .Pcomp(pcomp_b), .Error(error_b),
        .Intgrl(intgrl_b), .Icomp(icomp_b), .lft(lft_b), .rht(rht_b),
        .busy(busy_b), .done(done_b));

    // ---------------- A2D responder ----------------
    initial begin
        logic [2:0] ch;
        int         d;
        cnv_cmplt = 1'b0;
        a2d_res   = 12'h000;
        forever begin
            @(negedge clk);
            if (strt_cnv_a) begin
                ch = chnnl_a;
                d  = (strt_idx < 6) ? cnv_delay[strt_idx] : 3;
                if (strt_idx < 6) chan_log[strt_idx] = ch;
                strt_idx++;
                repeat (d) @(negedge clk);
                a2d_res   = chan_val[ch];
                cnv_cmplt = 1'b1;
                @(negedge clk);
                cnv_cmplt = 1'b0;
            end
        end
    end

    // Count cycles with strt_cnv high
    initial forever begin
        @(negedge clk);
        if (strt_cnv_a) strt_high++;
    end

    // Scoreboard: compare on done
    initial forever begin
        @(negedge clk);
        if (done_a) begin
            done_cnt++;
            check_val("done_b", done_b, 1);
            check_val("sb_size", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_val("a_accum",  accum_a,  mon_e.a.accum);
                check_val("a_pcomp",  pcomp_a,  mon_e.a.pcomp);
                check_val("a_error",  error_a,  mon_e.a.error);
                check_val("a_intgrl", intgrl_a, mon_e.a.intgrl);
                check_val("a_icomp",  icomp_a,  mon_e.a.icomp);
                check_val("a_lft",    lft_a,    mon_e.a.lft);
                check_val("a_rht",    rht_a,    mon_e.a.rht);
                check_val("b_accum",  accum_b,  mon_e.b.accum);
                check_val("b_error",  error_b,  mon_e.b.error);
                check_val("b_intgrl", intgrl_b, mon_e.b.intgrl);
                check_val("b_icomp",  icomp_b,  mon_e.b.icomp);
                check_val("b_lft",    lft_b,    mon_e.b.lft);
                check_val("b_rht",    rht_b,    mon_e.b.rht);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus tasks ----------------
    task automatic check_zero(input string tag);
        check_val({tag, "_regs16"}, {accum_a, pcomp_a}, 32'h0);
        check_val({tag, "_regs12a"}, {error_a, intgrl_a}, 32'h0);
        check_val({tag, "_regs12b"}, {icomp_a, lft_a}, 32'h0);
        check_val({tag, "_rht"}, rht_a, 32'h0);
        check_val({tag, "_ctl"}, {strt_cnv_a, busy_a, done_a, chnnl_a}, 32'h0);
        check_val({tag, "_alu"}, {src1sel_a, src0sel_a, mult2_a, mult4_a, sub_a,
                                  multiply_a, saturate_a}, 32'h0);
        check_val({tag, "_b"}, {accum_b, error_b, intgrl_b, busy_b}, 32'h0);
    endtask

    task automatic set_sensors(input logic [5:0][11:0] sv);
        for (int i = 0; i < 8; i++) chan_val[i] = 12'h000;
        for (int i = 0; i < 6; i++) chan_val[tb_chan(3'(i))] = sv[i];
    endtask

    task automatic run_pass(input logic [5:0][11:0] sv, input int d3, input bit go_at_done);
        int  lat, exp_lat, done_before;
        sb_t e;
        set_sensors(sv);
        for (int i = 0; i < 6; i++) cnv_delay[i] = 3;
        cnv_delay[3] = d3;
        pass_a++;
        e.a = model(sv, intg_a, (pass_a % INT_DEC_A) == 0);
        e.b = model(sv, intg_b, 1'b1);
        intg_a = e.a.intgrl;
        intg_b = e.b.intgrl;
        sb_q.push_back(e);
        strt_high   = 0;
        strt_idx    = 0;
        chan_log    = '0;
        done_before = done_cnt;
        exp_lat     = 5 * (SETTLE + 2 + 3) + (SETTLE + 2 + d3) + 8;
        go = 1'b1;
        @(negedge clk);
        go  = 1'b0;
        lat = 1;
        while (!done_a && lat < 4000) begin
            @(negedge clk);
            lat++;
            go = (lat == 40);
            if (d3 > 100 && lat == 200) begin
                check_val("busy_in_long_wait", busy_a, 1);
                check_val("strt_in_long_wait", strt_high, 4);
            end
        end
        go = 1'b0;
        check_val("latency", lat, exp_lat);
        check_val("strt_pulses", strt_high, 6);
        check_val("chan_seq", chan_log, {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1});
        if (go_at_done) begin
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            check_val("go_at_done_ignored", busy_a, 0);
        end
        @(negedge clk);
        check_val("done_count", done_cnt - done_before, 1);
    endtask

    task automatic abort_run();
        int done_before, guard;
        set_sensors({12'h111, 12'h222, 12'h333, 12'h044, 12'h055, 12'h066});
        for (int i = 0; i < 6; i++) cnv_delay[i] = 3;
        cnv_delay[2] = 30;
        strt_high   = 0;
        strt_idx    = 0;
        done_before = done_cnt;
        go = 1'b1;
        @(negedge clk);
        go    = 1'b0;
        guard = 0;
        while (strt_high < 3 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check_val("abort_reach_s2", strt_high, 3);
        repeat (5) @(negedge clk);
        check_val("abort_busy_before", busy_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        intg_a = 12'h000;
        intg_b = 12'h000;
        pass_a = 0;
        repeat (40) @(negedge clk);
        check_zero("abort");
        check_val("abort_no_done", done_cnt - done_before, 0);
        check_val("abort_strt", strt_high, 3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 6; i++) cnv_delay[i] = 3;
        for (int i = 0; i < 8; i++) chan_val[i] = 12'h000;
        chan_log = '0;
        rst = 1'b1;
        go  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("after_reset");

        // all sensors equal: weighted error cancels
        run_pass({6{12'h100}}, 3, 1'b0);
        check_val("r1_error", error_a, 12'h000);
        // right sensors only: positive saturation
        run_pass({12'h000, 12'h200, 12'h000, 12'h200, 12'h000, 12'h200}, 3, 1'b0);
        check_val("r2_error", error_a, 12'h7FF);
        check_val("r2_intgrl_dec1", intgrl_b, 12'h07F);
        // left sensors only: negative saturation
        run_pass({12'h200, 12'h000, 12'h200, 12'h000, 12'h200, 12'h000}, 3, 1'b0);
        check_val("r3_error", error_a, 12'h800);
        // distinct readings, plus go presented on the done edge
        run_pass({12'h00F, 12'h033, 12'h010, 12'h0AB, 12'h045, 12'h123}, 3, 1'b1);

        abort_run();

        // constant Error=0x7FF: decimated integral moves on passes 4 and 8
        for (int p = 1; p <= 8; p++) begin
            run_pass({12'h000, 12'h200, 12'h000, 12'h200, 12'h000, 12'h200},
                     (p == 5) ? 200 : 3, 1'b0);
            if (p == 3) check_val("dec_pass3", intgrl_a, 12'h000);
            if (p == 4) check_val("dec_pass4", intgrl_a, 12'h07F);
            if (p == 7) check_val("dec_pass7", intgrl_a, 12'h07F);
            if (p == 8) check_val("dec_pass8", intgrl_a, 12'h0FE);
        end

        repeat (5) @(negedge clk);
        check_val("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
